cpu_bus_initiator: RTL and testbench



---
 rtl/duck_bus_pkg.sv | 19 +
 rtl/cpu_bus_initiator.sv | 182 ++++++++++++++++++
 tb/tb_cpu_bus_initiator.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/duck_bus_pkg.sv
// Shared types and widths for the CPU-side 8-bit external bus initiator.
package duck_bus_pkg;

  localparam int unsigned BUS_ADDR_W = 16;
  localparam int unsigned BUS_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRelease,
    StResp
  } bus_state_e;

  // Timeout counter width; never below one bit so a disabled timeout still elaborates.
  function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/cpu_bus_initiator.sv
// CPU-side bus master: byte / little-endian 16-bit accesses over a four-phase
// strobe/done handshake, with an optional timeout on the strobe phase.
module cpu_bus_initiator
  import duck_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic                  i_req_word,
  input  logic [BUS_ADDR_W-1:0] i_req_addr,
  input  logic [15:0]           i_req_wdata,
  output logic                  o_resp_valid,
  output logic [15:0]           o_resp_rdata,
  output logic                  o_resp_error,
  output logic [BUS_ADDR_W-1:0] o_bus_address_out,
  output logic [BUS_DATA_W-1:0] o_bus_data_out,
  output logic                  o_bus_read,
  output logic                  o_bus_write,
  input  logic [BUS_DATA_W-1:0] i_bus_data_in,
  input  logic                  i_bus_done
);

  localparam int unsigned CntW = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);
  localparam bit TmoEn = (TIMEOUT_CYCLES != 0);

  bus_state_e            r_state, w_state;
  logic                  r_write, w_write;
  logic                  r_word, w_word;
  logic [BUS_ADDR_W-1:0] r_addr, w_addr;
  logic [15:0]           r_wdata, w_wdata;
  logic                  r_byte_idx, w_byte_idx;
  logic [CntW-1:0]       r_cnt, w_cnt, w_cnt_inc;
  logic                  r_err, w_err;
  logic [15:0]           r_rdata, w_rdata;
  logic [BUS_ADDR_W-1:0] r_bus_addr, w_bus_addr;
  logic [BUS_DATA_W-1:0] r_bus_data, w_bus_data;
  logic                  r_bus_rd, w_bus_rd;
  logic                  r_bus_wr, w_bus_wr;
  logic                  r_resp_valid, w_resp_valid;
  logic [15:0]           r_resp_rdata, w_resp_rdata;
  logic                  r_resp_error, w_resp_error;
  logic                  r_req_ready, w_req_ready;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state      = r_state;
    w_write      = r_write;
    w_word       = r_word;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_byte_idx   = r_byte_idx;
    w_cnt        = r_cnt;
    w_err        = r_err;
    w_rdata      = r_rdata;
    w_bus_addr   = r_bus_addr;
    w_bus_data   = r_bus_data;
    w_bus_rd     = r_bus_rd;
    w_bus_wr     = r_bus_wr;
    w_resp_valid = 1'b0;
    w_resp_rdata = r_resp_rdata;
    w_resp_error = r_resp_error;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid && r_req_ready) begin
          w_write    = i_req_write;
          w_word     = i_req_word;
          w_addr     = i_req_addr;
          w_wdata    = i_req_wdata;
          w_byte_idx = 1'b0;
          w_cnt      = '0;
          w_err      = 1'b0;
          w_rdata    = '0;
          w_bus_addr = i_req_addr;
          w_bus_data = i_req_write ? i_req_wdata[7:0] : '0;
          w_bus_rd   = !i_req_write;
          w_bus_wr   = i_req_write;
          w_state    = StReq;
        end
      end
      StReq: begin
        if (i_bus_done) begin
          if (!r_write) begin
            if (r_byte_idx) w_rdata[15:8] = i_bus_data_in;
            else            w_rdata[7:0]  = i_bus_data_in;
          end
          w_bus_rd = 1'b0;
          w_bus_wr = 1'b0;
          w_state  = StRelease;
        end else if (TmoEn && (w_cnt_inc == CntMax)) begin
          w_bus_rd = 1'b0;
          w_bus_wr = 1'b0;
          w_err    = 1'b1;
          w_state  = StRelease;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      StRelease: begin
        if (!i_bus_done) begin
          if (r_word && !r_err && !r_byte_idx) begin
            // Second byte of a little-endian word: next address, high data byte.
            w_byte_idx = 1'b1;
            w_bus_addr = r_addr + 1'b1;
            w_bus_data = r_write ? r_wdata[15:8] : '0;
            w_bus_rd   = !r_write;
            w_bus_wr   = r_write;
            w_cnt      = '0;
            w_state    = StReq;
          end else begin
            w_resp_valid = 1'b1;
            w_resp_rdata = (r_write || r_err) ? 16'h0000 : r_rdata;
            w_resp_error = r_err;
            w_state      = StResp;
          end
        end
      end
      StResp: begin
        w_bus_data = '0;
        w_state    = StIdle;
      end
      default: w_state = StIdle;
    endcase
    // A done still high from a previous access blocks new requests.
    w_req_ready = (w_state == StIdle) && !i_bus_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_write      <= 1'b0;
      r_word       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_byte_idx   <= 1'b0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
      r_bus_addr   <= '0;
      r_bus_data   <= '0;
      r_bus_rd     <= 1'b0;
      r_bus_wr     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
      r_req_ready  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_write      <= w_write;
      r_word       <= w_word;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_byte_idx   <= w_byte_idx;
      r_cnt        <= w_cnt;
      r_err        <= w_err;
      r_rdata      <= w_rdata;
      r_bus_addr   <= w_bus_addr;
      r_bus_data   <= w_bus_data;
      r_bus_rd     <= w_bus_rd;
      r_bus_wr     <= w_bus_wr;
      r_resp_valid <= w_resp_valid;
      r_resp_rdata <= w_resp_rdata;
      r_resp_error <= w_resp_error;
      r_req_ready  <= w_req_ready;
    end
  end

  assign o_req_ready       = r_req_ready;
  assign o_resp_valid      = r_resp_valid;
  assign o_resp_rdata      = r_resp_rdata;
  assign o_resp_error      = r_resp_error;
  assign o_bus_address_out = r_bus_addr;
  assign o_bus_data_out    = r_bus_data;
  assign o_bus_read        = r_bus_rd;
  assign o_bus_write       = r_bus_wr;

endmodule

// File: tb/tb_cpu_bus_initiator.sv
// Directed bench for cpu_bus_initiator against a one-cycle registered responder model.
module tb_cpu_bus_initiator;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_word;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_error;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_din;
  logic        bus_done;

  logic        rsp_en;
  logic        force_done;
  logic        rsp_done_q;
  logic [7:0]  rsp_din_q;

  int n_cmp = 0;
  int n_bad = 0;

  int          n_pulse = 0;
  int          n_strobe_cyc = 0;
  int          n_overlap = 0;
  int          n_resp = 0;
  logic        prev_strobe = 1'b0;
  logic [15:0] log_addr[32];
  logic [7:0]  log_data[32];
  logic        log_wr[32];

  cpu_bus_initiator #(
    .TIMEOUT_CYCLES(4)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_write      (req_write),
    .i_req_word       (req_word),
    .i_req_addr       (req_addr),
    .i_req_wdata      (req_wdata),
    .o_resp_valid     (resp_valid),
    .o_resp_rdata     (resp_rdata),
    .o_resp_error     (resp_error),
    .o_bus_address_out(bus_addr),
    .o_bus_data_out   (bus_dout),
    .o_bus_read       (bus_rd),
    .o_bus_write      (bus_wr),
    .i_bus_data_in    (bus_din),
    .i_bus_done       (bus_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rsp_byte(input logic [15:0] a);
    if (a == 16'h0000) return 8'h3E;
    if (a == 16'h0001) return 8'h55;
    return a[7:0] ^ 8'hA5;
  endfunction

  // Responder: done follows the strobe one cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_done_q <= 1'b0;
      rsp_din_q  <= 8'h00;
    end else begin
      rsp_done_q <= rsp_en && (bus_rd || bus_wr);
      rsp_din_q  <= rsp_byte(bus_addr);
    end
  end
  assign bus_done = rsp_done_q | force_done;
  assign bus_din  = rsp_din_q;

  always @(negedge clk) begin
    if ((bus_rd || bus_wr) && !prev_strobe && n_pulse < 32) begin
      log_addr[n_pulse] = bus_addr;
      log_data[n_pulse] = bus_dout;
      log_wr[n_pulse]   = bus_wr;
    end
    if ((bus_rd || bus_wr) && !prev_strobe) n_pulse++;
    if (bus_rd || bus_wr) n_strobe_cyc++;
    if (bus_rd && bus_wr) n_overlap++;
    if (resp_valid) n_resp++;
    prev_strobe = bus_rd || bus_wr;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, return edges from accept to resp_valid plus the response.
  task automatic do_req(input logic wr, input logic wd, input logic [15:0] a,
                        input logic [15:0] d, output int lat, output logic [15:0] rd,
                        output logic er);
    int waited;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_word  = wd;
    req_addr  = a;
    req_wdata = d;
    waited    = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) check_val("accept_timeout", 32'(waited), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    rd  = 16'hxxxx;
    er  = 1'bx;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (resp_valid) break;
    end
    if (!resp_valid) check_val("resp_timeout", 32'(lat), 32'd0);
    rd = resp_rdata;
    er = resp_error;
  endtask

  initial begin
    int          lat;
    logic [15:0] rd;
    logic        er;
    int          p0;
    int          s0;
    int          r0;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_word   = 1'b0;
    req_addr   = 16'h0;
    req_wdata  = 16'h0;
    rsp_en     = 1'b1;
    force_done = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_strobes", {30'd0, bus_rd, bus_wr}, 32'd0);
    check_val("rst_resp", {15'd0, resp_valid, resp_rdata}, 32'd0);
    check_val("rst_addr", {8'd0, bus_addr, bus_dout}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("ready_after_rst", 32'(req_ready), 32'd1);

    // Byte read at 0x0001
    p0 = n_pulse;
    do_req(1'b0, 1'b0, 16'h0001, 16'h0000, lat, rd, er);
    check_val("byte_rd_lat", 32'(lat), 32'd4);
    check_val("byte_rd_data", 32'(rd), 32'h0055);
    check_val("byte_rd_err", 32'(er), 32'd0);
    check_val("byte_rd_pulses", 32'(n_pulse - p0), 32'd1);
    check_val("byte_rd_addr", {15'd0, log_wr[p0], log_addr[p0]}, 32'h0000_0001);

    // Word read at 0x0000
    p0 = n_pulse;
    do_req(1'b0, 1'b1, 16'h0000, 16'h0000, lat, rd, er);
    check_val("word_rd_lat", 32'(lat), 32'd8);
    check_val("word_rd_data", 32'(rd), 32'h553E);
    check_val("word_rd_pulses", 32'(n_pulse - p0), 32'd2);
    check_val("word_rd_addr0", 32'(log_addr[p0]), 32'h0000);
    check_val("word_rd_addr1", 32'(log_addr[p0+1]), 32'h0001);

    // Word write 0xBEEF at 0xFFFF wraps to 0x0000
    p0 = n_pulse;
    do_req(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, lat, rd, er);
    check_val("word_wr_lat", 32'(lat), 32'd8);
    check_val("word_wr_resp", {15'd0, er, rd}, 32'd0);
    check_val("word_wr_pulses", 32'(n_pulse - p0), 32'd2);
    check_val("word_wr_b0", {7'd0, log_wr[p0], log_addr[p0], log_data[p0]}, 32'h01FF_FFEF);
    check_val("word_wr_b1", {7'd0, log_wr[p0+1], log_addr[p0+1], log_data[p0+1]},
              32'h0100_00BE);
    @(negedge clk);
    @(negedge clk);
    check_val("idle_bus_hold", {8'd0, bus_addr, bus_dout}, 32'h0000_0000);

    // Timeout, byte read
    rsp_en = 1'b0;
    p0 = n_pulse;
    s0 = n_strobe_cyc;
    do_req(1'b0, 1'b0, 16'h0042, 16'h0000, lat, rd, er);
    check_val("tmo_strobe_cyc", 32'(n_strobe_cyc - s0), 32'd4);
    check_val("tmo_lat", 32'(lat), 32'd5);
    check_val("tmo_resp", {15'd0, er, rd}, 32'h0001_0000);

    // Timeout on byte 0 of a word skips byte 1
    p0 = n_pulse;
    do_req(1'b0, 1'b1, 16'h0001, 16'h0000, lat, rd, er);
    check_val("tmo_word_pulses", 32'(n_pulse - p0), 32'd1);
    check_val("tmo_word_resp", {15'd0, er, rd}, 32'h0001_0000);
    rsp_en = 1'b1;

    // Stale done blocks acceptance
    @(negedge clk);
    force_done = 1'b1;
    repeat (2) @(negedge clk);
    p0 = n_pulse;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_word  = 1'b0;
    req_addr  = 16'h0001;
    repeat (3) @(negedge clk);
    check_val("stale_ready", 32'(req_ready), 32'd0);
    check_val("stale_no_strobe", 32'(n_pulse - p0), 32'd0);
    force_done = 1'b0;
    @(negedge clk);
    check_val("stale_ready_back", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check_val("stale_accepted", 32'(bus_rd), 32'd1);
    begin
      int t = 0;
      while (!resp_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      check_val("stale_resp", {15'd0, resp_valid, resp_rdata}, 32'h0001_0055);
    end

    // Reset asserted during REQ of a read
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1;
    req_word  = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0010;
    @(negedge clk);
    req_valid = 1'b0;
    check_val("mid_rst_in_req", 32'(bus_rd), 32'd1);
    r0 = n_resp;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_strobe", {30'd0, bus_rd, bus_wr}, 32'd0);
    check_val("mid_rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("post_rst_ready", 32'(req_ready), 32'd1);
    check_val("post_rst_no_resp", 32'(n_resp - r0), 32'd0);

    check_val("no_overlap", 32'(n_overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
